// File: rtl/xmit_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xmit_sched_pkg
// Brief    : Shared types and constants for the transmit priority scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package xmit_sched_pkg;

    localparam int LEN_W_DEF = 12;
    localparam int MIN_LEN   = 64;
    localparam int MAX_LEN   = 1518;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        IFG   = 2'd3
    } sched_state_t;

    // A zero-cycle gap still needs a 1-bit counter to keep the timer legal
    function automatic int ifg_cnt_w(input int cycles);
        return (cycles <= 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xmit_ifg_timer.sv
`default_nettype none
// ============================================================================
// Module   : xmit_ifg_timer
// Brief    : Inter-frame gap down-counter; loads IFG_CYCLES-1, stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module xmit_ifg_timer
    import xmit_sched_pkg::*;
#(
    parameter int IFG_CYCLES = 48
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int c_cnt_w = ifg_cnt_w(IFG_CYCLES);
    localparam logic [c_cnt_w-1:0] c_load_val =
        c_cnt_w'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (count_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/xmit_prio_sched.sv
`default_nettype none
// ============================================================================
// Module   : xmit_prio_sched
// Brief    : Strict-priority frame scheduler with length check and IFG.
//            Optional low-starvation guard: XMIT_LO_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xmit_prio_sched
    import xmit_sched_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int IFG_CYCLES = 48
`ifdef XMIT_LO_STARVE_GUARD_EN
    ,
    parameter int HI_BURST_MAX = 8
`endif
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hi_ctrl_valid,
    input  logic [LEN_W-1:0] hi_ctrl_len,
    output logic             hi_ctrl_pop,
    input  logic             lo_ctrl_valid,
    input  logic [LEN_W-1:0] lo_ctrl_len,
    output logic             lo_ctrl_pop,
    output logic             tx_start,
    output logic             tx_sel_hi,
    output logic [LEN_W-1:0] tx_len,
    input  logic             tx_done,
    output logic             m_discard_en,
    output logic             busy
);

    localparam logic [LEN_W-1:0] c_min_len = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic             r_sel_hi;
    logic             w_arb;
    logic             w_lo_force;
    logic             w_pick_lo;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_len_ok;
    logic             w_ifg_load;
    logic             w_ifg_expired;

    // Pops are gated by reset so no control word is lost during reset
    assign w_arb     = (r_state == IDLE) && (hi_ctrl_valid || lo_ctrl_valid) && !reset;
    assign w_pick_lo = lo_ctrl_valid && (!hi_ctrl_valid || w_lo_force);
    assign w_sel_len = w_pick_lo ? lo_ctrl_len : hi_ctrl_len;
    assign w_len_ok  = (w_sel_len >= c_min_len) && (w_sel_len <= c_max_len);

`ifdef XMIT_LO_STARVE_GUARD_EN
    localparam int c_run_w = $clog2(HI_BURST_MAX + 1);

    logic [c_run_w-1:0] r_hi_run;

    assign w_lo_force = (r_hi_run == c_run_w'(HI_BURST_MAX));

    // Counts high grants that made a waiting low frame wait longer
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hi_run <= '0;
        end else if (w_arb) begin
            if (!lo_ctrl_valid || w_pick_lo) begin
                r_hi_run <= '0;
            end else begin
                r_hi_run <= r_hi_run + 1'b1;
            end
        end
    end
`else
    assign w_lo_force = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_sel_hi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb && w_len_ok) begin
                r_len    <= w_sel_len;
                r_sel_hi <= !w_pick_lo;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        hi_ctrl_pop  = 1'b0;
        lo_ctrl_pop  = 1'b0;
        m_discard_en = 1'b0;
        tx_start     = 1'b0;
        w_ifg_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb) begin
                    hi_ctrl_pop = !w_pick_lo;
                    lo_ctrl_pop = w_pick_lo;
                    if (w_len_ok) begin
                        w_state_nxt = START;
                    end else begin
                        m_discard_en = 1'b1;
                    end
                end
            end
            START: begin
                tx_start    = 1'b1;
                w_state_nxt = BUSY;
            end
            BUSY: begin
                if (tx_done) begin
                    if (IFG_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = IFG;
                        w_ifg_load  = 1'b1;
                    end
                end
            end
            IFG: begin
                if (w_ifg_expired) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    xmit_ifg_timer #(
        .IFG_CYCLES (IFG_CYCLES)
    ) u_ifg_timer (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load     (w_ifg_load),
        .count_en (r_state == IFG),
        .expired  (w_ifg_expired)
    );

    assign tx_sel_hi = r_sel_hi;
    assign tx_len    = r_len;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xmit_prio_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xmit_prio_sched
// Brief    : Self-checking bench: queue/timeline model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xmit_prio_sched;
    import xmit_sched_pkg::*;

    localparam int LEN_W = 12;
    localparam int IFG   = 48;
`ifdef XMIT_LO_STARVE_GUARD_EN
    localparam int BURST     = 8;
    localparam int D_LO_POS  = 8;
`else
    localparam int D_LO_POS  = 10;
`endif

    typedef struct packed {
        logic [31:0]      cyc;
        logic             hi;
        logic             disc;
        logic [LEN_W-1:0] len;
    } pop_t;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic             hi_ctrl_valid = 1'b0, lo_ctrl_valid = 1'b0, tx_done = 1'b0;
    logic [LEN_W-1:0] hi_ctrl_len = '0, lo_ctrl_len = '0;
    logic             hi_ctrl_pop, lo_ctrl_pop, tx_start, tx_sel_hi, m_discard_en, busy;
    logic [LEN_W-1:0] tx_len;

    logic             z_reset = 1'b1, z_hi_valid = 1'b0, z_lo_valid = 1'b0, z_done = 1'b0;
    logic [LEN_W-1:0] z_hi_len = '0, z_lo_len = '0;
    logic             z_hi_pop, z_lo_pop, z_start, z_sel, z_disc, z_busy;
    logic [LEN_W-1:0] z_len;

    always #5 clk_sys = ~clk_sys;

    xmit_prio_sched #(
        .LEN_W        (LEN_W),
        .IFG_CYCLES   (IFG)
`ifdef XMIT_LO_STARVE_GUARD_EN
        ,
        .HI_BURST_MAX (BURST)
`endif
    ) u_dut (
        .clk_sys (clk_sys), .reset (reset),
        .hi_ctrl_valid (hi_ctrl_valid), .hi_ctrl_len (hi_ctrl_len), .hi_ctrl_pop (hi_ctrl_pop),
        .lo_ctrl_valid (lo_ctrl_valid), .lo_ctrl_len (lo_ctrl_len), .lo_ctrl_pop (lo_ctrl_pop),
        .tx_start (tx_start), .tx_sel_hi (tx_sel_hi), .tx_len (tx_len), .tx_done (tx_done),
        .m_discard_en (m_discard_en), .busy (busy)
    );

    xmit_prio_sched #(
        .LEN_W      (LEN_W),
        .IFG_CYCLES (0)
    ) u_dut_z (
        .clk_sys (clk_sys), .reset (z_reset),
        .hi_ctrl_valid (z_hi_valid), .hi_ctrl_len (z_hi_len), .hi_ctrl_pop (z_hi_pop),
        .lo_ctrl_valid (z_lo_valid), .lo_ctrl_len (z_lo_len), .lo_ctrl_pop (z_lo_pop),
        .tx_start (z_start), .tx_sel_hi (z_sel), .tx_len (z_len), .tx_done (z_done),
        .m_discard_en (z_disc), .busy (z_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [LEN_W-1:0] hq[$];
    logic [LEN_W-1:0] lq[$];
    pop_t             plog[$];
    int               slog[$];
    int               slen[$];
    int               ssel[$];
    int               dlog[$];

    bit eng_on = 0, spur_en = 0, force_done = 0;
    int eng_cnt = 0, eng_min = 6, eng_max = 6;

    // Timeline model: a frame occupies the scheduler from grant until its
    // done pulse, after which arbitration resumes IFG cycles later.
    bit               m_in_frame = 0;
    int               m_idle_at = 0;
    int               m_start_cyc = 0;
    bit               m_sel = 0;
    logic [LEN_W-1:0] m_len = '0;
    int               m_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LEN_W-1:0] rand_len();
        case ($urandom_range(0, 6))
            0:       return LEN_W'(63);
            1:       return LEN_W'(64);
            2:       return LEN_W'(1518);
            3:       return LEN_W'(1519);
            4:       return LEN_W'($urandom_range(0, 4095));
            default: return LEN_W'($urandom_range(64, 1518));
        endcase
    endfunction

    function automatic void clear_logs();
        plog.delete(); slog.delete(); slen.delete(); ssel.delete(); dlog.delete();
    endfunction

    task automatic step(input bit rst_in);
        bit               hv, lv, free, pick_lo, legal, force_lo;
        bit               e_hi, e_lo, e_disc, e_start, e_busy;
        logic [LEN_W-1:0] hl, ll, sl;
        @(posedge clk_sys);
        #1;
        cyc++;
        hv = (hq.size() > 0);
        lv = (lq.size() > 0);
        hl = hv ? hq[0] : LEN_W'($urandom);
        ll = lv ? lq[0] : LEN_W'($urandom);
        reset = rst_in;
        hi_ctrl_valid = hv; hi_ctrl_len = hl;
        lo_ctrl_valid = lv; lo_ctrl_len = ll;
        tx_done = 1'b0;
        if (rst_in) begin
            eng_on = 0;
        end else if (force_done) begin
            tx_done = 1'b1;
            force_done = 0;
        end else if (eng_on) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                tx_done = 1'b1;
                eng_on = 0;
                dlog.push_back(cyc);
            end
        end else if (spur_en && $urandom_range(0, 9) == 0) begin
            tx_done = 1'b1;
        end
        @(negedge clk_sys);
        if (rst_in) begin
            m_in_frame = 0; m_idle_at = 0; m_run = 0;
            return;
        end
        free = !m_in_frame && (cyc >= m_idle_at);
`ifdef XMIT_LO_STARVE_GUARD_EN
        force_lo = (m_run == BURST);
`else
        force_lo = 1'b0;
`endif
        pick_lo = lv && (!hv || force_lo);
        sl      = pick_lo ? ll : hl;
        legal   = (int'(sl) >= MIN_LEN) && (int'(sl) <= MAX_LEN);
        e_hi    = free && hv && !pick_lo;
        e_lo    = free && pick_lo;
        e_disc  = free && (hv || lv) && !legal;
        e_start = m_in_frame && (cyc == m_start_cyc);
        e_busy  = !free;
        chk("hi_ctrl_pop", hi_ctrl_pop, e_hi);
        chk("lo_ctrl_pop", lo_ctrl_pop, e_lo);
        chk("m_discard_en", m_discard_en, e_disc);
        chk("tx_start", tx_start, e_start);
        chk("busy", busy, e_busy);
        if (m_in_frame && cyc >= m_start_cyc) begin
            chk("tx_sel_hi", tx_sel_hi, m_sel);
            chk("tx_len", tx_len, m_len);
        end
        if (hi_ctrl_pop && hv) begin
            void'(hq.pop_front());
            plog.push_back('{cyc: cyc, hi: 1'b1, disc: m_discard_en, len: hl});
        end
        if (lo_ctrl_pop && lv) begin
            void'(lq.pop_front());
            plog.push_back('{cyc: cyc, hi: 1'b0, disc: m_discard_en, len: ll});
        end
        if (tx_start) begin
            eng_on  = 1;
            eng_cnt = $urandom_range(eng_min, eng_max);
            slog.push_back(cyc); slen.push_back(int'(tx_len)); ssel.push_back(int'(tx_sel_hi));
        end
        if (m_in_frame && cyc > m_start_cyc && tx_done) begin
            m_in_frame = 0;
            m_idle_at  = cyc + 1 + IFG;
        end
        if (free && (hv || lv)) begin
            m_run = (!lv || pick_lo) ? 0 : m_run + 1;
            if (legal) begin
                m_in_frame  = 1;
                m_start_cyc = cyc + 1;
                m_sel       = !pick_lo;
                m_len       = sl;
            end
        end
    endtask

    task automatic run_until_idle(input int max_cyc, input string tag);
        int  n = 0;
        bit  idle = 0;
        while (!idle && n < max_cyc) begin
            step(0);
            n++;
            idle = (hq.size() == 0) && (lq.size() == 0) && !eng_on && !m_in_frame && (cyc >= m_idle_at);
        end
        chk({tag, "_drain"}, idle, 1);
    endtask

    task automatic z_cycle(input bit done, input bit e_pop, input bit e_start, input bit e_busy,
                           input string tag);
        @(posedge clk_sys);
        #1;
        z_reset = 1'b0;
        z_done  = done;
        @(negedge clk_sys);
        chk({tag, "_pop"}, z_hi_pop, e_pop);
        chk({tag, "_start"}, z_start, e_start);
        chk({tag, "_busy"}, z_busy, e_busy);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lo_pos;
        step(1); step(1); step(0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_sel_hi", tx_sel_hi, 0);
        chk("rst_tx_len", tx_len, 0);
        chk("rst_discard", m_discard_en, 0);

        // Single high frame: pop at N, start at N+1
        clear_logs();
        hq.push_back(LEN_W'(512));
        run_until_idle(300, "A");
        chk("A_pops", plog.size(), 1);
        chk("A_hi", plog[0].hi, 1);
        chk("A_start_lat", slog[0] - int'(plog[0].cyc), 1);
        chk("A_len", slen[0], 512);
        chk("A_sel", ssel[0], 1);

        // Both valid together: high first, low one IFG after done
        clear_logs();
        hq.push_back(LEN_W'(512));
        lq.push_back(LEN_W'(64));
        run_until_idle(400, "B");
        chk("B_pops", plog.size(), 2);
        chk("B_first_hi", plog[0].hi, 1);
        chk("B_second_lo", plog[1].hi, 0);
        chk("B_gap", int'(plog[1].cyc) - dlog[0], 49);
        chk("B_lo_len", slen[1], 64);
        chk("B_lo_sel", ssel[1], 0);

        // Illegal heads are discarded back-to-back with no gap afterwards
        clear_logs();
        lq.push_back(LEN_W'(40));
        lq.push_back(LEN_W'(2000));
        lq.push_back(LEN_W'(100));
        run_until_idle(300, "C");
        chk("C_pops", plog.size(), 3);
        chk("C_disc0", plog[0].disc, 1);
        chk("C_disc1", plog[1].disc, 1);
        chk("C_disc2", plog[2].disc, 0);
        chk("C_back2back", int'(plog[1].cyc) - int'(plog[0].cyc), 1);
        chk("C_no_ifg", int'(plog[2].cyc) - int'(plog[1].cyc), 1);
        chk("C_starts", slog.size(), 1);
        chk("C_len", slen[0], 100);

        // Ten high and one low queued at once
        clear_logs();
        for (int i = 0; i < 10; i++) hq.push_back(LEN_W'(512));
        lq.push_back(LEN_W'(64));
        run_until_idle(3000, "D");
        chk("D_count", plog.size(), 11);
        lo_pos = -1;
        for (int i = 0; i < plog.size(); i++)
            if (!plog[i].hi) lo_pos = i;
        chk("D_lo_pos", lo_pos, D_LO_POS);

        // Reset while busy abandons the frame; a later done gives no IFG
        clear_logs();
        eng_min = 30; eng_max = 30;
        hq.push_back(LEN_W'(512));
        repeat (4) step(0);
        chk("E_busy_before", busy, 1);
        step(1);
        step(0);
        chk("E_busy", busy, 0);
        chk("E_tx_start", tx_start, 0);
        chk("E_tx_sel_hi", tx_sel_hi, 0);
        chk("E_tx_len", tx_len, 0);
        chk("E_pops", {30'd0, hi_ctrl_pop, lo_ctrl_pop}, 0);
        chk("E_discard", m_discard_en, 0);
        force_done = 1;
        step(0);
        step(0);
        chk("E_no_ifg", busy, 0);
        hq.push_back(LEN_W'(100));
        step(0);
        chk("E_pop_now", hi_ctrl_pop, 1);
        eng_min = 6; eng_max = 6;
        run_until_idle(300, "E");

        // Randomized traffic with spurious done pulses and rare resets
        spur_en = 1; eng_min = 1; eng_max = 12;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) hq.push_back(rand_len());
            if ($urandom_range(0, 7) == 0) lq.push_back(rand_len());
            step($urandom_range(0, 399) == 0);
        end
        run_until_idle(20000, "R");
        spur_en = 0;

        // Zero-gap instance: next pop on the cycle after done
        z_hi_valid = 1'b1;
        z_hi_len   = LEN_W'(100);
        z_cycle(0, 1, 0, 0, "Z0");
        z_cycle(0, 0, 1, 1, "Z1");
        chk("Z1_len", z_len, 100);
        chk("Z1_sel", z_sel, 1);
        z_cycle(0, 0, 0, 1, "Z2");
        z_cycle(1, 0, 0, 1, "Z3");
        z_cycle(0, 1, 0, 0, "Z4");
        z_cycle(0, 0, 1, 1, "Z5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xmit_prio_sched.md
# xmit_prio_sched

Frame-level priority scheduler for the transmit path, on `clk_sys`. It watches the high- and low-priority control-word FIFOs and picks the next frame. It checks the frame length, pops the chosen control word, and starts the transmit engine. It then enforces the inter-frame gap before it arbitrates again. Illegal lengths are dropped with a one-cycle discard pulse, and the engine is never started for them.

## Interface
Parameters:
- `LEN_W`, 12, width of the frame-length field (`ctrl[LEN_W-1:0]` of the 24-bit control word)
- `IFG_CYCLES`, 48, idle `clk_sys` cycles between `tx_done` and the next arbitration
- `HI_BURST_MAX`, 8, consecutive high grants allowed while low waits (guard feature only)

Ports:
- `clk_sys`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `hi_ctrl_valid`  in  1  high-priority control FIFO not empty
- `hi_ctrl_len`  in  LEN_W  length (bytes) at head of high FIFO
- `hi_ctrl_pop`  out  1  pop high FIFO head
- `lo_ctrl_valid`  in  1  low-priority control FIFO not empty
- `lo_ctrl_len`  in  LEN_W  length at head of low FIFO
- `lo_ctrl_pop`  out  1  pop low FIFO head
- `tx_start`  out  1  one-cycle start pulse to transmit engine
- `tx_sel_hi`  out  1  1 = engine reads the high data FIFO; held from `tx_start` until `tx_done`
- `tx_len`  out  LEN_W  frame length to engine; held like `tx_sel_hi`
- `tx_done`  in  1  one-cycle pulse when the engine has sent the last nibble
- `m_discard_en`  out  1  one-cycle pulse; the selected frame had an illegal length and is discarded
- `busy`  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: arbitrates when any valid is high. Pops the chosen queue in the same cycle; the pop is a Mealy output.
    - Length legal (`MIN_LEN` ≤ len ≤ `MAX_LEN`): latch len/sel → START.
    - Length illegal: assert `m_discard_en` with the pop and stay in IDLE. There is no IFG after a discard.
  - START: `tx_start`=1 for exactly one cycle → BUSY.
  - BUSY: wait for `tx_done`. On `tx_done` → IFG, or → IDLE if `IFG_CYCLES`=0.
  - IFG: count down from `IFG_CYCLES`-1. At 0 → IDLE.
- Arbitration is strict priority: high wins whenever `hi_ctrl_valid`=1. When both are valid on the same cycle, high is popped and low is untouched.
- At most one pop per cycle. Pops occur only in IDLE.
- `tx_done` outside BUSY is ignored. It carries no state and raises no error.
- Valids that change during START/BUSY/IFG are sampled only on return to IDLE.
- Reset values: `hi_ctrl_pop`=0, `lo_ctrl_pop`=0, `tx_start`=0, `tx_sel_hi`=0, `tx_len`=0, `m_discard_en`=0, `busy`=0, state=IDLE, counters=0.
- Reset mid-frame: return to IDLE next cycle and abandon the frame. The engine is reset by the same `reset`.

## Timing
- Latency: `*_ctrl_valid` high in IDLE at cycle N gives pop at N, `tx_start` at N+1, and `busy`=1 from N+1.
- `tx_done` at cycle D gives the earliest next pop at D+1+`IFG_CYCLES`.
- Back-to-back discards: one pop per cycle while illegal heads keep arriving.
- The IFG counter is `$clog2(IFG_CYCLES+1)` bits wide and never wraps.
- Length compare is unsigned on `LEN_W` bits.

## Configuration
- `XMIT_LO_STARVE_GUARD_EN` defined:
  - A run counter (width `$clog2(HI_BURST_MAX+1)`) increments on each high grant made while `lo_ctrl_valid`=1.
  - It clears on a low grant, or on any IDLE arbitration where `lo_ctrl_valid`=0.
  - When the counter equals `HI_BURST_MAX` and both are valid, low is granted.
  - A discarded frame counts as a grant for its queue.
- Undefined: pure strict priority. The counter is not instantiated.

## Structure
- `xmit_sched_pkg` holds:
  - the FSM state enum (IDLE, START, BUSY, IFG)
  - `MIN_LEN`=64 and `MAX_LEN`=1518
  - the default `LEN_W`
- One sub-module, `xmit_ifg_timer`: load, count down and `expired` flag for the IFG state.

## Test plan
- Reset, then only `hi_ctrl_valid` with len 512 → `hi_ctrl_pop` at N, `tx_start` at N+1, `tx_sel_hi`=1, `tx_len`=512.
- Both valid, hi len 512 and lo len 64 → high served first. Low is popped at `tx_done`+1+48 with `tx_len`=64 and `tx_sel_hi`=0.
- Lo len 40, then lo len 2000 → two consecutive `m_discard_en` pulses with `lo_ctrl_pop` and no `tx_start`. A legal frame after them starts immediately, with no IFG.
- Guard on, `HI_BURST_MAX`=8, ten high frames of len 512 and one low frame of len 64 all queued:
  - order is 8 high, 1 low, 2 high.
  - Guard off: 10 high, then 1 low.
- `reset` asserted during BUSY → next cycle all outputs are 0 and state is IDLE. A `tx_done` pulse afterwards does not produce an IFG.
- `IFG_CYCLES`=0 with continuous high frames → next pop on the cycle after `tx_done`.
